alu_op_decoder: RTL and testbench
=================================

// Module: alu_op_decoder
// PURPOSE
//  Decode-stage producer of the ALU SELECT code: takes fetched RV32IM instruction words and emits
//  registered ALU control (5-bit select, operand muxing, immediate, register indices) to the EX stage.
//  Sits between IF and EX. Valid/ready on both sides, 2-entry skid buffer, pipeline flush.
// PARAMETERS
//  none. Select codes and opcodes are constants in the shared package.
// PORTS
//  CLK          in   1   clock, rising edge
//  RESET        in   1   synchronous, active-high reset
//  FLUSH        in   1   discard all held and incoming instructions (branch/jump redirect)
//  IN_VALID     in   1   INSTRUCTION/PC valid
//  IN_READY     out  1   decoder can accept this cycle
//  INSTRUCTION  in   32  instruction word
//  PC           in   32  instruction address, passed through
//  OUT_VALID    out  1   decoded bundle valid
//  OUT_READY    in   1   EX stage accepts bundle
//  ALU_SELECT   out  5   ALU operation code (table below)
//  OP_A_SEL     out  1   0=rs1, 1=PC
//  OP_B_SEL     out  2   00=rs2, 01=IMM, 10=constant 4
//  IMM          out  32  sign-extended immediate (I/S/B/U/J by format)
//  RD, RS1, RS2 out  5   register indices
//  REG_WRITE    out  1   rd written back (forced 0 when RD==0)
//  PC_OUT       out  32  PC of the decoded instruction
//  ILLEGAL      out  1   unsupported encoding; REG_WRITE=0, ALU_SELECT=ADD
// BEHAVIOUR
//  Select: FWD 11111 ADD 00000 SUB 00010 SLL 00100 SLT 01000 SLTU 01100 XOR 10000 SRL 10100
//   SRA 10110 OR 11000 AND 11100 MUL 00001 MULH 00101 MULHU 01001 MULHSU 01101 DIV 10001
//   DIVU 10101 REM 11001 REMU 11101.
//  OP(0110011): funct7 0000000 -> base op by funct3; 0100000 -> SUB(f3=000)/SRA(f3=101);
//   0000001 -> M op by funct3; any other funct7/f3 combination ILLEGAL. B=rs2.
//  OP-IMM(0010011): op by funct3, B=IMM(I); SLLI needs funct7=0; f3=101 -> SRLI(0)/SRAI(0100000).
//  LUI: FWD, B=IMM(U). AUIPC: ADD, A=PC, B=IMM(U). LOAD: ADD, B=IMM(I), write.
//  STORE: ADD, B=IMM(S), no write. BRANCH: SUB, B=rs2, IMM(B), no write.
//  JAL/JALR: ADD, A=PC, B=4, write; IMM=J/I. Any other opcode: ILLEGAL.
//  Latency: accepted word visible on outputs the next cycle (1 cycle) when buffer empty.
//  Handshake: transfer on VALID&&READY per side. Outputs stable while OUT_VALID&&!OUT_READY.
//  Skid: main + skid entry. IN_READY = !skid_full, registered. Order strictly preserved.
//  Full: both entries held, IN_READY=0; drain of main moves skid->main same edge.
//  Simultaneous in+out on one-entry buffer: occupancy unchanged, no bubble.
//  FLUSH: next edge clears both entries, OUT_VALID=0; word accepted in flush cycle dropped.
//   FLUSH has priority over accept and drain. FLUSH during RESET: RESET wins (same effect).
//  Reset: OUT_VALID=0, IN_READY=0 during RESET, 1 the cycle after; all data outputs 0.
// CONFIGURATION
//  RV32M_EN defined: funct7=0000001 under OP decodes to MUL..REMU.
//  RV32M_EN undefined: those encodings ILLEGAL=1, REG_WRITE=0, ALU_SELECT=ADD.
// STRUCTURE
//  Package rv32im_pkg: opcode constants, 5-bit ALU select constants, OP_B_SEL encodings,
//   decoded-bundle struct (shared by EX-stage ALU instantiation).
//  Sub-module alu_op_decode_comb: pure combinational instr->bundle decode; top holds
//   handshake and skid buffer registering the decoded bundle.
// TESTING
//  0x002081B3 (add x3,x1,x2) -> next cycle SELECT=00000, RD=3 RS1=1 RS2=2, B_SEL=00, REG_WRITE=1.
//  0x407302B3 (sub x5,x6,x7) -> SELECT=00010; 0xFFF00093 (addi x1,x0,-1) -> ADD, IMM=0xFFFFFFFF, B_SEL=01.
//  0x02C58533 (mul x10,x11,x12) -> SELECT=00001 with RV32M_EN; ILLEGAL=1, REG_WRITE=0 without.
//  0x12345137 (lui x2,0x12345) -> SELECT=11111, IMM=0x12345000; 0x0000006F (jal x0) -> REG_WRITE=0.
//  OUT_READY=0 3 cycles, 3 words offered -> 2 held, IN_READY=0, then drained in order, no loss.
//  FLUSH with 2 held and IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, flushed word never emitted.

Source files
------------

// File: rtl/rv32im_pkg.sv
// Shared RV32IM decode constants and the decoded-bundle type handed from the
// decode stage to the EX-stage ALU.
package rv32im_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   localparam logic A_SEL_RS1 = 1'b0;
   localparam logic A_SEL_PC  = 1'b1;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'b00000,
      ALU_MUL    = 5'b00001,
      ALU_SUB    = 5'b00010,
      ALU_SLL    = 5'b00100,
      ALU_MULH   = 5'b00101,
      ALU_SLT    = 5'b01000,
      ALU_MULHU  = 5'b01001,
      ALU_SLTU   = 5'b01100,
      ALU_MULHSU = 5'b01101,
      ALU_XOR    = 5'b10000,
      ALU_DIV    = 5'b10001,
      ALU_SRL    = 5'b10100,
      ALU_DIVU   = 5'b10101,
      ALU_SRA    = 5'b10110,
      ALU_OR     = 5'b11000,
      ALU_REM    = 5'b11001,
      ALU_AND    = 5'b11100,
      ALU_REMU   = 5'b11101,
      ALU_FWD    = 5'b11111
   } alu_sel_e;

   typedef enum logic [1:0] {
      B_SEL_RS2  = 2'b00,
      B_SEL_IMM  = 2'b01,
      B_SEL_FOUR = 2'b10
   } op_b_sel_e;

   typedef struct packed {
      alu_sel_e    alu_sel;
      logic        op_a_sel;
      op_b_sel_e   op_b_sel;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        reg_write;
      logic        illegal;
      logic [31:0] pc;
   } dec_bundle_t;

endpackage

// File: rtl/alu_op_decode_comb.sv
// Pure combinational RV32IM instruction -> ALU control bundle decode.
// Define RV32M_EN to decode the multiply/divide group; otherwise it is ILLEGAL.
module alu_op_decode_comb
   import rv32im_pkg::*;
(
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc,
   output dec_bundle_t o_bundle
);

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic [4:0]  w_rd;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_imm_j;

   alu_sel_e    w_alu;
   logic        w_a_sel;
   op_b_sel_e   w_b_sel;
   logic [31:0] w_imm;
   logic        w_write;
   logic        w_illegal;

   assign w_opcode = i_instr[6:0];
   assign w_rd     = i_instr[11:7];
   assign w_funct3 = i_instr[14:12];
   assign w_funct7 = i_instr[31:25];

   assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
   assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
   assign w_imm_b = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
   assign w_imm_u = {i_instr[31:12], 12'b0};
   assign w_imm_j = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

   always_comb begin
      // NOTE: every signal gets a default first so no decode path can infer a latch.
      w_alu     = ALU_ADD;
      w_a_sel   = A_SEL_RS1;
      w_b_sel   = B_SEL_RS2;
      w_imm     = '0;
      w_write   = 1'b0;
      w_illegal = 1'b0;

      case (w_opcode)
         OPC_OP: begin
            w_write = 1'b1;
            case (w_funct7)
               F7_BASE: begin
                  case (w_funct3)
                     3'b000: w_alu = ALU_ADD;
                     3'b001: w_alu = ALU_SLL;
                     3'b010: w_alu = ALU_SLT;
                     3'b011: w_alu = ALU_SLTU;
                     3'b100: w_alu = ALU_XOR;
                     3'b101: w_alu = ALU_SRL;
                     3'b110: w_alu = ALU_OR;
                     3'b111: w_alu = ALU_AND;
                  endcase
               end
               F7_ALT: begin
                  if (w_funct3 == 3'b000)      w_alu = ALU_SUB;
                  else if (w_funct3 == 3'b101) w_alu = ALU_SRA;
                  else                         w_illegal = 1'b1;
               end
               F7_MULDIV: begin
`ifdef RV32M_EN
                  case (w_funct3)
                     3'b000: w_alu = ALU_MUL;
                     3'b001: w_alu = ALU_MULH;
                     3'b010: w_alu = ALU_MULHSU;
                     3'b011: w_alu = ALU_MULHU;
                     3'b100: w_alu = ALU_DIV;
                     3'b101: w_alu = ALU_DIVU;
                     3'b110: w_alu = ALU_REM;
                     3'b111: w_alu = ALU_REMU;
                  endcase
`else
                  w_illegal = 1'b1;
`endif
               end
               default: w_illegal = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            w_write = 1'b1;
            w_b_sel = B_SEL_IMM;
            w_imm   = w_imm_i;
            // Shift-immediates reuse funct7 as an opcode extension; other funct3 values treat it as immediate bits.
            case (w_funct3)
               3'b000: w_alu = ALU_ADD;
               3'b001: begin
                  if (w_funct7 == F7_BASE) w_alu = ALU_SLL;
                  else                     w_illegal = 1'b1;
               end
               3'b010: w_alu = ALU_SLT;
               3'b011: w_alu = ALU_SLTU;
               3'b100: w_alu = ALU_XOR;
               3'b101: begin
                  if (w_funct7 == F7_BASE)     w_alu = ALU_SRL;
                  else if (w_funct7 == F7_ALT) w_alu = ALU_SRA;
                  else                         w_illegal = 1'b1;
               end
               3'b110: w_alu = ALU_OR;
               3'b111: w_alu = ALU_AND;
            endcase
         end
         OPC_LUI: begin
            w_alu   = ALU_FWD;
            w_b_sel = B_SEL_IMM;
            w_imm   = w_imm_u;
            w_write = 1'b1;
         end
         OPC_AUIPC: begin
            w_a_sel = A_SEL_PC;
            w_b_sel = B_SEL_IMM;
            w_imm   = w_imm_u;
            w_write = 1'b1;
         end
         OPC_LOAD: begin
            w_b_sel = B_SEL_IMM;
            w_imm   = w_imm_i;
            w_write = 1'b1;
         end
         OPC_STORE: begin
            w_b_sel = B_SEL_IMM;
            w_imm   = w_imm_s;
         end
         OPC_BRANCH: begin
            w_alu = ALU_SUB;
            w_imm = w_imm_b;
         end
         OPC_JAL: begin
            w_a_sel = A_SEL_PC;
            w_b_sel = B_SEL_FOUR;
            w_imm   = w_imm_j;
            w_write = 1'b1;
         end
         OPC_JALR: begin
            w_a_sel = A_SEL_PC;
            w_b_sel = B_SEL_FOUR;
            w_imm   = w_imm_i;
            w_write = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase

      // An illegal encoding degrades to a harmless ADD with no writeback.
      if (w_illegal) begin
         w_alu   = ALU_ADD;
         w_a_sel = A_SEL_RS1;
         w_b_sel = B_SEL_RS2;
         w_imm   = '0;
         w_write = 1'b0;
      end
   end

   always_comb begin
      o_bundle           = '0;
      o_bundle.alu_sel   = w_alu;
      o_bundle.op_a_sel  = w_a_sel;
      o_bundle.op_b_sel  = w_b_sel;
      o_bundle.imm       = w_imm;
      o_bundle.rd        = w_rd;
      o_bundle.rs1       = i_instr[19:15];
      o_bundle.rs2       = i_instr[24:20];
      o_bundle.reg_write = w_write && (w_rd != 5'd0);
      o_bundle.illegal   = w_illegal;
      o_bundle.pc        = i_pc;
   end

endmodule

// File: rtl/alu_op_decoder.sv
// Decode stage between IF and EX: decodes each accepted word and holds it in a
// two-entry (main + skid) registered buffer with valid/ready and flush. Macro: RV32M_EN.
module alu_op_decoder
   import rv32im_pkg::*;
(
   input  logic        CLK,
   input  logic        RESET,
   input  logic        FLUSH,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [31:0] INSTRUCTION,
   input  logic [31:0] PC,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [4:0]  ALU_SELECT,
   output logic        OP_A_SEL,
   output logic [1:0]  OP_B_SEL,
   output logic [31:0] IMM,
   output logic [4:0]  RD,
   output logic [4:0]  RS1,
   output logic [4:0]  RS2,
   output logic        REG_WRITE,
   output logic [31:0] PC_OUT,
   output logic        ILLEGAL
);

   dec_bundle_t w_dec;
   dec_bundle_t r_main;
   dec_bundle_t r_skid;
   dec_bundle_t w_main_nxt;
   dec_bundle_t w_skid_nxt;
   logic        r_main_valid;
   logic        r_skid_valid;
   logic        w_main_valid_nxt;
   logic        w_skid_valid_nxt;
   logic        r_in_ready;
   logic        w_accept;
   logic        w_drain;

   alu_op_decode_comb u_decode (
      .i_instr  (INSTRUCTION),
      .i_pc     (PC),
      .o_bundle (w_dec)
   );

   assign w_accept = IN_VALID && r_in_ready;
   assign w_drain  = r_main_valid && OUT_READY;

   // Main always holds the oldest word; skid only fills while main is stalled.
   always_comb begin
      w_main_nxt       = r_main;
      w_skid_nxt       = r_skid;
      w_main_valid_nxt = r_main_valid;
      w_skid_valid_nxt = r_skid_valid;

      if (FLUSH) begin
         w_main_valid_nxt = 1'b0;
         w_skid_valid_nxt = 1'b0;
      end else if (!r_main_valid) begin
         if (w_accept) begin
            w_main_nxt       = w_dec;
            w_main_valid_nxt = 1'b1;
         end
      end else if (w_drain) begin
         if (r_skid_valid) begin
            w_main_nxt = r_skid;
            if (w_accept) w_skid_nxt       = w_dec;
            else          w_skid_valid_nxt = 1'b0;
         end else if (w_accept) begin
            w_main_nxt = w_dec;
         end else begin
            w_main_valid_nxt = 1'b0;
         end
      end else if (w_accept && !r_skid_valid) begin
         w_skid_nxt       = w_dec;
         w_skid_valid_nxt = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         // NOTE: the data registers are reset too, so every output reads 0 out of reset.
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b0;
      end else begin
         r_main       <= w_main_nxt;
         r_skid       <= w_skid_nxt;
         r_main_valid <= w_main_valid_nxt;
         r_skid_valid <= w_skid_valid_nxt;
         // Ready is registered from next-state occupancy so IN_READY never depends on OUT_READY combinationally.
         r_in_ready   <= !w_skid_valid_nxt;
      end
   end

   assign IN_READY   = r_in_ready;
   assign OUT_VALID  = r_main_valid;
   assign ALU_SELECT = r_main.alu_sel;
   assign OP_A_SEL   = r_main.op_a_sel;
   assign OP_B_SEL   = r_main.op_b_sel;
   assign IMM        = r_main.imm;
   assign RD         = r_main.rd;
   assign RS1        = r_main.rs1;
   assign RS2        = r_main.rs2;
   assign REG_WRITE  = r_main.reg_write;
   assign PC_OUT     = r_main.pc;
   assign ILLEGAL    = r_main.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Scoreboard bench for alu_op_decoder: hand-derived expected bundles are queued on
// input acceptance and compared on output transfer. Honours RV32M_EN.
module tb_alu_op_decoder;

   logic        CLK;
   logic        RESET;
   logic        FLUSH;
   logic        IN_VALID;
   logic        IN_READY;
   logic [31:0] INSTRUCTION;
   logic [31:0] PC;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [4:0]  ALU_SELECT;
   logic        OP_A_SEL;
   logic [1:0]  OP_B_SEL;
   logic [31:0] IMM;
   logic [4:0]  RD;
   logic [4:0]  RS1;
   logic [4:0]  RS2;
   logic        REG_WRITE;
   logic [31:0] PC_OUT;
   logic        ILLEGAL;

`ifdef RV32M_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif

   typedef struct {
      int          idx;
      logic [31:0] instr;
      logic [4:0]  sel;
      logic        a;
      logic [1:0]  b;
      logic [31:0] imm;
      logic        chk_imm;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        rw;
      logic        ill;
      logic [31:0] pc;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   cur_idx = 0;
   bit   rand_ready = 1'b0;

   alu_op_decoder dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .FLUSH       (FLUSH),
      .IN_VALID    (IN_VALID),
      .IN_READY    (IN_READY),
      .INSTRUCTION (INSTRUCTION),
      .PC          (PC),
      .OUT_VALID   (OUT_VALID),
      .OUT_READY   (OUT_READY),
      .ALU_SELECT  (ALU_SELECT),
      .OP_A_SEL    (OP_A_SEL),
      .OP_B_SEL    (OP_B_SEL),
      .IMM         (IMM),
      .RD          (RD),
      .RS1         (RS1),
      .RS2         (RS2),
      .REG_WRITE   (REG_WRITE),
      .PC_OUT      (PC_OUT),
      .ILLEGAL     (ILLEGAL)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] instr, input logic [4:0] sel, input logic a,
                      input logic [1:0] b, input logic [31:0] imm, input logic chk_imm,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic rw, input logic ill);
      vec_t v;
      v.idx = tbl.size();
      v.instr = instr; v.sel = sel; v.a = a; v.b = b; v.imm = imm; v.chk_imm = chk_imm;
      v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.rw = rw; v.ill = ill; v.pc = '0;
      tbl.push_back(v);
   endtask

   task automatic compare(input vec_t e);
      check($sformatf("v%0d.sel", e.idx), ALU_SELECT, e.sel);
      check($sformatf("v%0d.a_sel", e.idx), OP_A_SEL, e.a);
      check($sformatf("v%0d.b_sel", e.idx), OP_B_SEL, e.b);
      if (e.chk_imm) check($sformatf("v%0d.imm", e.idx), IMM, e.imm);
      check($sformatf("v%0d.rd", e.idx), RD, e.rd);
      check($sformatf("v%0d.rs1", e.idx), RS1, e.rs1);
      check($sformatf("v%0d.rs2", e.idx), RS2, e.rs2);
      check($sformatf("v%0d.reg_write", e.idx), REG_WRITE, e.rw);
      check($sformatf("v%0d.illegal", e.idx), ILLEGAL, e.ill);
      check($sformatf("v%0d.pc", e.idx), PC_OUT, e.pc);
   endtask

   // Scoreboard: push on input handshake, pop/compare on output handshake.
   initial begin : monitor
      vec_t e;
      forever begin
         @(negedge CLK);
         if (RESET || FLUSH) begin
            sb.delete();
         end else begin
            if (OUT_VALID && OUT_READY) begin
               if (sb.size() == 0) begin
                  check("unexpected_out", OUT_VALID, 1'b0);
               end else begin
                  e = sb.pop_front();
                  compare(e);
               end
            end
            if (IN_VALID && IN_READY) begin
               e = tbl[cur_idx];
               e.pc = PC;
               sb.push_back(e);
            end
         end
      end
   end

   task automatic send(input int idx, input logic [31:0] pc);
      int n;
      INSTRUCTION = tbl[idx].instr;
      PC          = pc;
      cur_idx     = idx;
      IN_VALID    = 1'b1;
      if (rand_ready) OUT_READY = ($urandom_range(0, 3) != 0);
      n = 0;
      @(negedge CLK);
      while (!IN_READY && n < 100) begin
         @(posedge CLK);
         #1;
         if (rand_ready) OUT_READY = ($urandom_range(0, 3) != 0);
         @(negedge CLK);
         n++;
      end
      if (n >= 100) check("send_timeout", IN_READY, 1'b1);
      @(posedge CLK);
      #1;
      IN_VALID = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      OUT_READY = 1'b1;
      while (sb.size() != 0 && n < 100) begin
         @(negedge CLK);
         n++;
      end
      check("drain_empty", sb.size(), 0);
      @(posedge CLK);
      #1;
      check("drain_idle_out_valid", OUT_VALID, 1'b0);
   endtask

   initial begin
      int c0;
      RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; INSTRUCTION = '0; PC = '0; OUT_READY = 1'b0;

      //  instr         sel                     a     b      imm           ci  rd  rs1 rs2 rw     ill
      add(32'h002081B3, 5'b00000,               1'b0, 2'b00, 32'h0,        0,  3,  1,  2, 1,     0);
      add(32'h407302B3, 5'b00010,               1'b0, 2'b00, 32'h0,        0,  5,  6,  7, 1,     0);
      add(32'hFFF00093, 5'b00000,               1'b0, 2'b01, 32'hFFFFFFFF, 1,  1,  0, 31, 1,     0);
      add(32'h02C58533, M_EN ? 5'b00001 : 5'b0, 1'b0, 2'b00, 32'h0,        0, 10, 11, 12, M_EN, !M_EN);
      add(32'h12345137, 5'b11111,               1'b0, 2'b01, 32'h12345000, 1,  2,  8,  3, 1,     0);
      add(32'h0000006F, 5'b00000,               1'b1, 2'b10, 32'h0,        1,  0,  0,  0, 0,     0);
      add(32'h4062D233, 5'b10110,               1'b0, 2'b00, 32'h0,        0,  4,  5,  6, 1,     0);
      add(32'h402091B3, 5'b00000,               1'b0, 2'b00, 32'h0,        0,  3,  1,  2, 0,     1);
      add(32'h40345393, 5'b10110,               1'b0, 2'b01, 32'h00000403, 1,  7,  8,  3, 1,     0);
      add(32'h40001093, 5'b00000,               1'b0, 2'b00, 32'h0,        0,  1,  0,  0, 0,     1);
      add(32'h00001297, 5'b00000,               1'b1, 2'b01, 32'h00001000, 1,  5,  0,  0, 1,     0);
      add(32'hFFC12303, 5'b00000,               1'b0, 2'b01, 32'hFFFFFFFC, 1,  6,  2, 28, 1,     0);
      add(32'h00712423, 5'b00000,               1'b0, 2'b01, 32'h00000008, 1,  8,  2,  7, 0,     0);
      add(32'hFE208CE3, 5'b00010,               1'b0, 2'b00, 32'hFFFFFFF8, 1, 25,  1,  2, 0,     0);
      add(32'h004280E7, 5'b00000,               1'b1, 2'b10, 32'h00000004, 1,  1,  5,  4, 1,     0);
      add(32'h010000EF, 5'b00000,               1'b1, 2'b10, 32'h00000010, 1,  1,  0, 16, 1,     0);
      add(32'hFFFFFFFF, 5'b00000,               1'b0, 2'b00, 32'h0,        0, 31, 31, 31, 0,     1);
      add(32'h025251B3, M_EN ? 5'b10101 : 5'b0, 1'b0, 2'b00, 32'h0,        0,  3,  4,  5, M_EN, !M_EN);
      add(32'h023130B3, M_EN ? 5'b01001 : 5'b0, 1'b0, 2'b00, 32'h0,        0,  1,  2,  3, M_EN, !M_EN);
      add(32'h003170B3, 5'b11100,               1'b0, 2'b00, 32'h0,        0,  1,  2,  3, 1,     0);
      add(32'h00208033, 5'b00000,               1'b0, 2'b00, 32'h0,        0,  0,  1,  2, 0,     0);

      // Reset behaviour
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_out_valid", OUT_VALID, 1'b0);
      check("rst_in_ready", IN_READY, 1'b0);
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      @(posedge CLK);
      #1;
      check("post_rst_in_ready", IN_READY, 1'b1);
      check("post_rst_out_valid", OUT_VALID, 1'b0);
      check("post_rst_sel", ALU_SELECT, 5'd0);
      check("post_rst_imm", IMM, 32'd0);
      check("post_rst_pc", PC_OUT, 32'd0);
      check("post_rst_rd", RD, 5'd0);
      check("post_rst_b_sel", OP_B_SEL, 2'd0);
      check("post_rst_reg_write", REG_WRITE, 1'b0);

      // One-cycle latency into an empty buffer
      OUT_READY = 1'b1;
      send(0, 32'h0000_1000);
      check("latency_out_valid", OUT_VALID, 1'b1);

      // Whole table under random back-pressure
      rand_ready = 1'b1;
      for (int i = 1; i < tbl.size(); i++) send(i, 32'h0000_2000 + 32'(i * 4));
      rand_ready = 1'b0;
      drain();

      // Simultaneous accept and drain: no bubbles
      OUT_READY = 1'b1;
      c0 = cyc;
      send(19, 32'h0000_2500);
      send(20, 32'h0000_2504);
      send(0,  32'h0000_2508);
      send(1,  32'h0000_250C);
      check("throughput_cycles", cyc - c0, 4);
      check("throughput_in_ready", IN_READY, 1'b1);
      drain();

      // Skid: stall output, offer three words
      OUT_READY = 1'b0;
      send(4, 32'h0000_3000);
      send(5, 32'h0000_3004);
      INSTRUCTION = tbl[6].instr; PC = 32'h0000_3008; cur_idx = 6; IN_VALID = 1'b1;
      @(negedge CLK);
      check("skid_in_ready", IN_READY, 1'b0);
      check("skid_out_valid", OUT_VALID, 1'b1);
      check("skid_hold_pc", PC_OUT, 32'h0000_3000);
      @(posedge CLK);
      #1;
      @(negedge CLK);
      check("skid_hold_pc2", PC_OUT, 32'h0000_3000);
      check("skid_hold_sel", ALU_SELECT, 5'b11111);
      check("skid_hold_in_ready", IN_READY, 1'b0);
      @(posedge CLK);
      #1;
      OUT_READY = 1'b1;
      send(6, 32'h0000_3008);
      drain();

      // Flush with both entries held and a word offered
      OUT_READY = 1'b0;
      send(7, 32'h0000_4000);
      send(8, 32'h0000_4004);
      INSTRUCTION = tbl[9].instr; PC = 32'h0000_4008; cur_idx = 9; IN_VALID = 1'b1; FLUSH = 1'b1;
      @(posedge CLK);
      #1;
      FLUSH = 1'b0; IN_VALID = 1'b0;
      check("flush_out_valid", OUT_VALID, 1'b0);
      check("flush_in_ready", IN_READY, 1'b1);

      // Flush drops a word accepted in the same cycle
      OUT_READY = 1'b1;
      INSTRUCTION = tbl[10].instr; PC = 32'h0000_5000; cur_idx = 10; IN_VALID = 1'b1; FLUSH = 1'b1;
      @(posedge CLK);
      #1;
      FLUSH = 1'b0; IN_VALID = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge CLK);
         check("flush_drop_out_valid", OUT_VALID, 1'b0);
      end
      @(posedge CLK);
      #1;
      send(11, 32'h0000_6000);
      check("post_flush_latency", OUT_VALID, 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
